// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, CSR bit positions and the
// memory-mapped addresses the load/store unit decodes for this block.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } spi_state_t;

   localparam int unsigned SPI_CSR_DONE_BIT = 0;
   localparam int unsigned SPI_CSR_CS_BIT   = 2;

   localparam logic [31:0] SPI_COMMAND_ADDR = 32'h800;
   localparam logic [31:0] SPI_CSR_ADDR     = 32'h801;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: down-counter that raises a one-cycle tick once every CLK_DIV
// enabled clk cycles. The tick is registered, so the first tick appears
// CLK_DIV+1 cycles after the clearing edge.
//
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset
//   en     - count while high
//   clear  - reload the counter and drop any pending tick (wins over en)
//   tick   - one-cycle pulse every CLK_DIV enabled cycles
module spi_sclk_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clear,
   output logic tick
);

   localparam logic [7:0] TC_LOAD = 8'(CLK_DIV - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= 8'd0;
         tick <= 1'b0;
      end else if (clear) begin
         cnt  <= TC_LOAD;
         tick <= 1'b0;
      end else if (en) begin
         tick <= (cnt == 8'd0);
         cnt  <= (cnt == 8'd0) ? TC_LOAD : cnt - 8'd1;
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, MSB first. A level-held trigger starts one
// 8-bit exchange; spi_done stays high until the trigger is released.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for spi_trigger; sclk and mosi low
//   ST_SHIFT | 16 SCLK half-periods: sample MISO on rise, shift MOSI on fall
//   ST_DONE  | spi_done high, response valid; wait for spi_trigger low
//
// Ports:
//   clk, rst       - system clock, asynchronous active-high reset
//   spi_trigger    - start request, held until spi_done is seen
//   spi_command    - byte to send, sampled when the transfer starts
//   spi_cs_ctrl    - software chip-select level (1 = deselected)
//   spi_done       - transfer complete (CSR done bit)
//   spi_response   - last byte received
//   spi_sclk       - serial clock
//   spi_mosi       - serial data out
//   spi_miso       - serial data in
//   spi_cs_n       - registered chip select to the pin
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_trigger,
   input  logic [7:0] spi_command,
   input  logic       spi_cs_ctrl,
   output logic       spi_done,
   output logic [7:0] spi_response,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n
);

   spi_state_t state;
   // Bit 7 of the command goes straight to spi_mosi at start, so only the
   // remaining seven bits need to be held for shifting.
   logic [6:0] tx_sr;
   logic [7:0] rx_sr;
   logic [2:0] bit_cnt;
   logic       tick;
   logic       div_clear;
   logic       div_en;

   assign div_clear = (state == ST_IDLE) && spi_trigger;
   assign div_en    = (state == ST_SHIFT);

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk   (clk),
      .rst   (rst),
      .en    (div_en),
      .clear (div_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         spi_sclk     <= 1'b0;
         spi_mosi     <= 1'b0;
         spi_done     <= 1'b0;
         spi_response <= 8'h00;
         tx_sr        <= 7'd0;
         rx_sr        <= 8'd0;
         bit_cnt      <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (spi_trigger) begin
                  tx_sr    <= spi_command[6:0];
                  spi_mosi <= spi_command[7];
                  rx_sr    <= 8'd0;
                  bit_cnt  <= 3'd0;
                  spi_sclk <= 1'b0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (tick) begin
                  if (!spi_sclk) begin
                     spi_sclk <= 1'b1;
                     rx_sr    <= {rx_sr[6:0], spi_miso};
                  end else begin
                     spi_sclk <= 1'b0;
                     if (bit_cnt == 3'd7) begin
                        spi_response <= rx_sr;
                        spi_done     <= 1'b1;
                        spi_mosi     <= 1'b0;
                        state        <= ST_DONE;
                     end else begin
                        spi_mosi <= tx_sr[6];
                        tx_sr    <= {tx_sr[5:0], 1'b0};
                        bit_cnt  <= bit_cnt + 3'd1;
                     end
                  end
               end
            end
            ST_DONE: begin
               // A trigger still held from the finished transfer must not
               // start another one; require a low sample first.
               if (!spi_trigger) begin
                  spi_done <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) spi_cs_n <= 1'b1;
      else     spi_cs_n <= spi_cs_ctrl;
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The parameter shall be CLK_DIV, default 4, giving the SCLK half-period in clk cycles; legal values are 1 to 255.
REQ-002 The clk port shall be an input, 1 bit wide, and is the single system clock; all logic is rising-edge.
REQ-003 The rst port shall be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 The spi_trigger port shall be an input, 1 bit wide: start request, level-held by the load/store unit until it sees spi_done.
REQ-005 The spi_command port shall be an input, 8 bits wide: byte to transmit, sampled only at start.
REQ-006 The spi_cs_ctrl port shall be an input, 1 bit wide: software chip-select level (SPI CSR bit 2; 1 = deselected).
REQ-007 The spi_done port shall be an output, 1 bit wide: transfer complete; drives SPI CSR bit 0.
REQ-008 The spi_response port shall be an output, 8 bits wide: last byte received on MISO.
REQ-009 The spi_sclk port shall be an output, 1 bit wide: serial clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 The spi_mosi port shall be an output, 1 bit wide: serial data out, MSB first.
REQ-011 The spi_miso port shall be an input, 1 bit wide: serial data in, MSB first.
REQ-012 The spi_cs_n port shall be an output, 1 bit wide: chip select to the pin.

Function
REQ-013 The FSM shall have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with spi_trigger=1 at a clk edge, the block shall latch spi_command into the TX shift register, drive spi_mosi=spi_command[7], clear the bit and divider counters, and enter SHIFT.
REQ-015 In SHIFT, the divider shall count CLK_DIV clk cycles per tick; each tick shall toggle spi_sclk.
REQ-016 On each spi_sclk 0->1 toggle, spi_miso shall be shifted into the RX register LSB, with earlier bits moving toward the MSB.
REQ-017 On each spi_sclk 1->0 toggle, the TX register shall shift left and spi_mosi shall present the next bit.
REQ-018 After the 8th 1->0 toggle, the block shall copy the RX register to spi_response, set spi_done=1 and enter DONE; spi_sclk shall then be 0.
REQ-019 spi_done shall rise exactly 16*CLK_DIV+1 clk cycles after the edge that accepted the trigger.
REQ-020 In DONE, spi_done shall be held at 1 until spi_trigger is sampled 0; the block shall then clear spi_done and return to IDLE.
REQ-021 A trigger that is still high in DONE shall not start a new transfer; a new transfer requires trigger=0 for at least one cycle.
REQ-022 spi_trigger and spi_command changes during SHIFT shall be ignored.
REQ-023 spi_response shall change only at completion and shall hold its value otherwise.
REQ-024 spi_mosi shall be 0 in IDLE and in DONE.
REQ-025 spi_cs_n shall be a registered copy of spi_cs_ctrl with one-cycle latency, independent of FSM state; the FSM shall not gate on chip select.
REQ-026 With CLK_DIV=1, spi_sclk shall toggle every clk cycle and the transfer shall still take 16 cycles.

Reset
REQ-027 While rst=1, the block shall be in IDLE with spi_sclk=0, spi_mosi=0, spi_done=0, spi_response=8'h00, spi_cs_n=1, and all counters and shift registers at 0.
REQ-028 Reset asserted mid-transfer shall abort immediately with no partial spi_response update; after release, a held trigger shall start a fresh transfer.

Structure
REQ-029 A shared package spi_pkg shall define the state enum, SPI_CSR_DONE_BIT=0, SPI_CSR_CS_BIT=2, and the addresses SPI_COMMAND_ADDR=32'h800 and SPI_CSR_ADDR=32'h801; the load/store unit shall use these same constants.
REQ-030 One sub-module, spi_sclk_gen, shall be instantiated: a divider taking enable/clear and producing a one-cycle tick every CLK_DIV cycles.

Verification
REQ-031 The bench shall use CLK_DIV=4, command 8'hA5, and a MISO model returning 8'h3C; it shall check the MOSI bits 1,0,1,0,0,1,0,1 on rising edges, spi_response=8'h3C, and spi_done rising at cycle 65.
REQ-032 The bench shall hold the trigger high through DONE for 10 cycles, then drop it; it shall check that spi_done stays 1, no second transfer starts, and spi_done=0 one cycle after trigger=0.
REQ-033 The bench shall assert rst at the 4th SCLK rising edge; it shall check that all outputs are at reset values immediately, spi_response is unchanged at 8'h00, and the next transfer of 8'hFF/MISO=1 gives 8'hFF.
REQ-034 The bench shall change spi_command from 8'h0F to 8'hF0 mid-SHIFT; it shall check that the transmitted byte is 8'h0F.
REQ-035 The bench shall toggle spi_cs_ctrl 1->0->1 while idle and while shifting; it shall check that spi_cs_n follows one cycle later each time and that the transfer is unaffected.
REQ-036 The bench shall run CLK_DIV=1 with command 8'h81; it shall check 16-cycle SCLK activity and spi_done at cycle 17.
